fetch_queue: RTL

Decoupled instruction-fetch unit with a parametrised prefetch FIFO, sitting between the icache and the IF/ID pipeline register. It owns the fetch PC, keeps at most one icache request in flight, and buffers up to DEPTH fetched instructions with their PCs. On a branch or jump redirect it flushes the queue, finishes any in-flight icache transaction without corrupting the cache handshake, discards that response, and restarts fetch at the new target.

---
 rtl/fetch_queue.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: owns the fetch PC, keeps one icache request in flight,
// and buffers fetched {pc, instr} pairs in a circular queue ahead of IF/ID.
module fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h00000060
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       icache_read,
    output logic [XLEN-1:0]            icache_addr,
    input  logic [31:0]                icache_rdata,
    input  logic                       icache_resp,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output logic [31:0]                deq_instr,
    output logic [XLEN-1:0]            deq_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic empty;
    logic enq;
    logic deq;

    assign empty = (count_q == '0);
    assign enq   = (state_q == FETCH) && icache_resp && !redirect;
    assign deq   = !empty && deq_ready && !redirect;

    // A redirect flushes the queue and suppresses that cycle's enqueue/dequeue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PW'(1);
            if (deq) head_d = head_q + PW'(1);
            if (enq && !deq) begin
                count_d = count_q + CW'(1);
            end else if (!enq && deq) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (count_q < DEPTH_C) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (redirect) begin
                    if (icache_resp) begin
                        fetch_pc_d = redirect_pc;
                    end else begin
                        // Keep the address stable until the outstanding response arrives.
                        pending_pc_d = redirect_pc;
                        state_d      = DRAIN;
                    end
                end else if (icache_resp) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = (count_d < DEPTH_C) ? FETCH : IDLE;
                end
            end
            DRAIN: begin
                if (icache_resp) begin
                    fetch_pc_d = redirect ? redirect_pc : pending_pc_q;
                    state_d    = FETCH;
                end else if (redirect) begin
                    pending_pc_d = redirect_pc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    // Payload storage needs no reset; outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail_q]    <= fetch_pc_q;
            instr_mem[tail_q] <= icache_rdata;
        end
    end

    assign icache_read = (state_q != IDLE);
    assign icache_addr = fetch_pc_q;
    assign deq_valid   = !empty;
    assign deq_instr   = empty ? '0 : instr_mem[head_q];
    assign deq_pc      = empty ? '0 : pc_mem[head_q];
    assign count       = count_q;

endmodule
